// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : regfile_pkg
//  Purpose   : Shared sizes, types and the write-back source encoding used by
//              the register-file write-back arbiter.
//  Revision  : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 4;
    localparam int DATA_W   = 8;

    typedef logic [SEL_W-1:0]  reg_sel_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Write-back sources; also the encoding of the last-grant state.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    // Request / grant bit positions inside the 2-bit vectors.
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module    : rr_arbiter2
//  Purpose   : Two-way round-robin arbiter. A lone request is granted
//              outright; when both request, the source that did not win last
//              time is granted. Purely combinational, one-hot (or zero) grant.
//  Revision  : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       [1:0] req,
    input  wb_src_e          last,
    output logic       [1:0] grant
);

    logic w_contested;

    assign w_contested = req[REQ_ALU] & req[REQ_MEM];

    // Grant selection: contested requests go to the source not granted last.
    always_comb begin
        grant = 2'b00;
        if (w_contested) begin
            if (last == WB_MEM) begin
                grant[REQ_ALU] = 1'b1;
            end else begin
                grant[REQ_MEM] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : regfile_wb_arbiter
//  Purpose   : Shares the single register-file write port between the ALU
//              result path and the memory-load path. Round-robin grant with a
//              valid/ready handshake, registered write drive (one cycle after
//              grant) and a busy scoreboard of registers with an in-flight
//              producer for decode hazard stalls.
//  Revision  : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [SEL_W-1:0]    alu_sel,
    input  logic [DATA_W-1:0]   alu_data,

    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [SEL_W-1:0]    mem_sel,
    input  logic [DATA_W-1:0]   mem_data,

    input  logic                claim_valid,
    input  logic [SEL_W-1:0]    claim_sel,

    output logic [NUM_REGS-1:0] busy,

    output logic                rf_we,
    output logic [SEL_W-1:0]    rf_sel_in,
    output logic [DATA_W-1:0]   rf_in
);

    wb_src_e             r_last;
    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_any_grant;
    reg_sel_t            w_grant_sel;
    reg_data_t           w_grant_data;
    logic [NUM_REGS-1:0] w_busy_set;
    logic [NUM_REGS-1:0] w_busy_clr;
    logic [NUM_REGS-1:0] w_busy_next;

    // Requests are masked during reset so no handshake can complete then.
    assign w_req[REQ_ALU] = alu_valid & ~rst;
    assign w_req[REQ_MEM] = mem_valid & ~rst;

    rr_arbiter2 u_rr_arbiter2 (
        .req   (w_req),
        .last  (r_last),
        .grant (w_grant)
    );

    assign alu_ready   = w_grant[REQ_ALU];
    assign mem_ready   = w_grant[REQ_MEM];
    assign w_any_grant = |w_grant;

    // Mux the winning source's destination and data onto the write path.
    always_comb begin
        w_grant_sel  = mem_sel;
        w_grant_data = mem_data;
        if (w_grant[REQ_ALU]) begin
            w_grant_sel  = alu_sel;
            w_grant_data = alu_data;
        end
    end

    // Scoreboard next state: a claim overrides a same-cycle clear of the same bit.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (claim_valid) begin
            w_busy_set[claim_sel] = 1'b1;
        end
        if (w_any_grant) begin
            w_busy_clr[w_grant_sel] = 1'b1;
        end
        w_busy_next = (busy & ~w_busy_clr) | w_busy_set;
    end

    // Registered write drive, last-grant state and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_sel_in <= '0;
            rf_in     <= '0;
            r_last    <= WB_MEM;
            busy      <= '0;
        end else begin
            rf_we <= w_any_grant;
            busy  <= w_busy_next;
            if (w_any_grant) begin
                rf_sel_in <= w_grant_sel;
                rf_in     <= w_grant_data;
                r_last    <= w_grant[REQ_ALU] ? WB_ALU : WB_MEM;
            end
        end
    end

endmodule : regfile_wb_arbiter
`default_nettype wire
